// File: rtl/btn_conditioner.sv
// Five-button front end: two-flop synchronizer, debounce filter and per-button
// auto-repeat, producing a debounced level and single-cycle press/repeat strobes.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 15000000,
  parameter logic [4:0]  REPEAT_MASK     = 5'b01111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  // Terminal values are one below the limit: the edge that would reach the
  // limit is the edge that acts, so counters never hold the limit itself.
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  for (genvar i = 0; i < 5; i++) begin : g_ch
    logic             sync_a;
    logic             sync_b;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_cnt_next;
    logic             level;
    logic             level_next;
    logic             pulse;
    logic             pulse_next;
    rpt_state_e       state;
    rpt_state_e       state_next;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_next;

    // NOTE: every signal assigned here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
      level_next  = level;
      db_cnt_next = '0;
      if (sync_b != level) begin
        if (db_cnt == DB_LAST) begin
          level_next = sync_b;
        end else begin
          db_cnt_next = db_cnt + DB_W'(1);
        end
      end
    end

    // The repeat FSM looks at the level being written this edge, so a release
    // landing on a repeat-due cycle suppresses that pulse.
    always_comb begin
      state_next   = state;
      rpt_cnt_next = rpt_cnt;
      pulse_next   = 1'b0;
      unique case (state)
        IDLE: begin
          rpt_cnt_next = '0;
          if (level_next && !level) begin
            pulse_next = 1'b1;
            if (REPEAT_MASK[i]) state_next = DELAY;
          end
        end
        DELAY: begin
          if (!level_next) begin
            state_next   = IDLE;
            rpt_cnt_next = '0;
          end else if (rpt_cnt == DELAY_LAST) begin
            pulse_next   = 1'b1;
            rpt_cnt_next = '0;
            state_next   = REPEAT;
          end else begin
            rpt_cnt_next = rpt_cnt + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (!level_next) begin
            state_next   = IDLE;
            rpt_cnt_next = '0;
          end else if (rpt_cnt == RATE_LAST) begin
            pulse_next   = 1'b1;
            rpt_cnt_next = '0;
          end else begin
            rpt_cnt_next = rpt_cnt + RPT_W'(1);
          end
        end
        default: begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end
      endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a  <= 1'b0;
        sync_b  <= 1'b0;
        db_cnt  <= '0;
        level   <= 1'b0;
        pulse   <= 1'b0;
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        sync_a  <= btn_raw[i];
        sync_b  <= sync_a;
        db_cnt  <= db_cnt_next;
        level   <= level_next;
        pulse   <= pulse_next;
        state   <= state_next;
        rpt_cnt <= rpt_cnt_next;
      end
    end

    assign btn_level[i] = level;
    assign btn_pulse[i] = pulse;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus randomized
// button activity compared cycle by cycle against a behavioural model.
module tb_btn_conditioner;

  localparam int          D    = 4;
  localparam int          RD   = 10;
  localparam int          RR   = 3;
  localparam logic [4:0]  MASK = 5'b01111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: edge k samples raw r[k]; the debounce window at edge k is the
  // synchronized history r[k-2] .. r[k-D-1]. Pulses come from arithmetic on
  // the number of edges since the accepted press.
  int         k;
  logic [4:0] hist[$];
  logic [4:0] m_level;
  logic [4:0] m_pulse;
  int         press_edge[5];
  logic [4:0] obs_level[256];
  logic [4:0] obs_pulse[256];

  task automatic model_reset();
    k = 0;
    hist.delete();
    hist.push_back('0);
    m_level = '0;
    m_pulse = '0;
    for (int b = 0; b < 5; b++) press_edge[b] = 0;
  endtask

  task automatic model_step(input logic [4:0] raw);
    logic [4:0] nxt;
    logic [4:0] s;
    bit         accept;
    int         idx;
    int         e;
    k++;
    hist.push_back(raw);
    nxt     = m_level;
    m_pulse = '0;
    for (int b = 0; b < 5; b++) begin
      accept = 1'b1;
      for (int j = 2; j <= D + 1; j++) begin
        idx = k - j;
        s   = (idx >= 1) ? hist[idx] : 5'b0;
        if (s[b] == m_level[b]) accept = 1'b0;
      end
      if (accept) nxt[b] = ~m_level[b];
      if (nxt[b] && !m_level[b]) begin
        m_pulse[b]    = 1'b1;
        press_edge[b] = k;
      end else if (nxt[b] && MASK[b]) begin
        e          = k - press_edge[b];
        m_pulse[b] = (e == RD) || (e > RD && ((e - RD) % RR) == 0);
      end
    end
    m_level = nxt;
  endtask

  // Called at a falling edge; drives raw, lets one rising edge pass, compares.
  task automatic step(input logic [4:0] raw);
    btn_raw = raw;
    @(posedge clk);
    model_step(raw);
    #1;
    if (k < 256) begin
      obs_level[k] = btn_level;
      obs_pulse[k] = btn_pulse;
    end
    check($sformatf("level@%0d", k), btn_level, m_level);
    check($sformatf("pulse@%0d", k), btn_pulse, m_pulse);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    btn_raw = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int exp_rpt[6] = '{6, 16, 19, 22, 25, 28};

  initial begin
    int         cnt;
    int         edges[$];
    int         rem[5];
    logic [4:0] cur;
    logic [4:0] p;

    // Asynchronous clear before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset_level", btn_level, 5'b0);
    check("reset_pulse", btn_pulse, 5'b0);

    // Clean press on Select (masked: one pulse only), then release
    apply_reset();
    for (int i = 0; i < 30; i++) step(5'b10000);
    for (int i = 0; i < 10; i++) step(5'b00000);
    check("sel_level_e5", obs_level[5][4], 1'b0);
    check("sel_level_e6", obs_level[6][4], 1'b1);
    check("sel_pulse_e6", obs_pulse[6], 5'b10000);
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      p = obs_pulse[i];
      if (p[4]) cnt++;
    end
    check("sel_pulse_count", cnt, 1);
    check("sel_level_e35", obs_level[35][4], 1'b1);
    check("sel_level_e36", obs_level[36][4], 1'b0);

    // Bounce on Up: runs of three never reach the debounce length
    apply_reset();
    for (int i = 1; i <= 20; i++) step((i % 4) != 0 ? 5'b00001 : 5'b00000);
    for (int i = 0; i < 8; i++) step(5'b00000);
    cnt = 0;
    for (int i = 1; i <= 28; i++) begin
      p = obs_level[i];
      if (p[0]) cnt++;
      p = obs_pulse[i];
      if (p[0]) cnt++;
    end
    check("bounce_activity", cnt, 0);

    // Auto-repeat on Right; the release lands on a repeat-due edge (31)
    apply_reset();
    for (int i = 0; i < 25; i++) step(5'b01000);
    for (int i = 0; i < 10; i++) step(5'b00000);
    edges.delete();
    for (int i = 1; i <= 35; i++) begin
      p = obs_pulse[i];
      if (p[3]) edges.push_back(i);
    end
    check("rpt_pulse_count", edges.size(), 6);
    for (int i = 0; i < 6 && i < edges.size(); i++)
      check($sformatf("rpt_edge%0d", i), edges[i], exp_rpt[i]);
    check("race_level_e30", obs_level[30][3], 1'b1);
    check("race_level_e31", obs_level[31][3], 1'b0);
    check("race_pulse_e31", obs_pulse[31][3], 1'b0);

    // Simultaneous press on Up and Left
    apply_reset();
    for (int i = 0; i < 8; i++) step(5'b00101);
    for (int i = 0; i < 8; i++) step(5'b00000);
    check("simul_pulse_e5", obs_pulse[5], 5'b00000);
    check("simul_pulse_e6", obs_pulse[6], 5'b00101);

    // Asynchronous reset while Right is repeating, raw still held
    apply_reset();
    for (int i = 0; i < 20; i++) step(5'b01000);
    #1 rst_n = 1'b0;
    #1;
    check("async_level", btn_level, 5'b0);
    check("async_pulse", btn_pulse, 5'b0);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) step(5'b01000);
    for (int i = 0; i < 10; i++) step(5'b00000);
    edges.delete();
    for (int i = 1; i <= 16; i++) begin
      p = obs_pulse[i];
      if (p[3]) edges.push_back(i);
    end
    check("rst_pulse_count", edges.size(), 2);
    if (edges.size() >= 2) begin
      check("rst_first_pulse", edges[0], 6);
      check("rst_first_repeat", edges[1], 16);
    end

    // Randomized independent activity on all buttons, with one mid-run reset
    apply_reset();
    cur = '0;
    for (int b = 0; b < 5; b++) rem[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) apply_reset();
      for (int b = 0; b < 5; b++) begin
        if (rem[b] == 0) begin
          cur[b] = 1'($urandom_range(0, 1));
          rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                               : int'($urandom_range(1, 6));
        end
        rem[b]--;
      end
      step(cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive synchronized cycles a new raw level must hold before it is accepted; legal range >=1.
REQ-002 Parameter REPEAT_DELAY, default 50000000, cycles from accepted press to first auto-repeat pulse; legal range >=1.
REQ-003 Parameter REPEAT_RATE, default 15000000, cycles between subsequent auto-repeat pulses; legal range >=1.
REQ-004 Parameter REPEAT_MASK, default 5'b01111, per-button auto-repeat enable (bits 3:0 Up/Down/Left/Right repeat; bit 4 Select does not).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 btn_raw  input  5  asynchronous, bouncing pushbutton levels, 1 = pressed; bit order [0]Up [1]Down [2]Left [3]Right [4]Select.
REQ-008 btn_level  output  5  debounced pressed level per button.
REQ-009 btn_pulse  output  5  single-cycle press/repeat strobes, consumed directly as the game modules' btn_pulse input.

Function
REQ-010 Each bit SHALL be processed by an independent, identical channel; no bit affects another.
REQ-011 Each channel SHALL pass btn_raw through a two-flop synchronizer; sync output = second flop.
REQ-012 Debounce counter, width $clog2(DEBOUNCE_CYCLES+1): cleared whenever sync == btn_level; incremented while sync != btn_level.
REQ-013 When the counter would reach DEBOUNCE_CYCLES, btn_level SHALL take the sync value and the counter SHALL clear on the same edge.
REQ-014 Bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave btn_level unchanged.
REQ-015 Latency: raw edge stable from cycle 0 -> btn_level changes at edge 2+DEBOUNCE_CYCLES.
REQ-016 btn_pulse is registered: asserted for exactly one cycle, coincident with the first cycle btn_level reads 1 after a 0->1 change.
REQ-017 Release (1->0) SHALL never generate a pulse.
REQ-018 Repeat FSM per channel, states IDLE, DELAY, REPEAT; repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
REQ-019 IDLE: on accepted press, emit edge pulse (REQ-016); go to DELAY with counter 0 if REPEAT_MASK bit set, else stay IDLE.
REQ-020 DELAY: counter increments each cycle; on the REPEAT_DELAY-th cycle after entry, pulse for one cycle, clear counter, go to REPEAT.
REQ-021 REPEAT: on every REPEAT_RATE-th cycle, pulse for one cycle and clear counter; remain in REPEAT.
REQ-022 In DELAY or REPEAT, btn_level==0 SHALL force IDLE, clear counter, suppress any pulse that cycle (release wins over a coincident repeat).
REQ-023 Masked-off channels SHALL emit exactly one pulse per accepted press regardless of hold time.
REQ-024 Multiple bits MAY pulse in the same cycle; no arbitration or prioritization.
REQ-025 No counter SHALL wrap; each saturates at its terminal count by construction of REQ-013/020/021.

Reset
REQ-026 rst_n low SHALL immediately clear synchronizer flops, debounce and repeat counters, btn_level=0, btn_pulse=0, all FSMs IDLE, without waiting for clk.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; a button held through reset release SHALL be re-debounced and produce one fresh press pulse at edge 2+DEBOUNCE_CYCLES after release.
REQ-028 Reset deassertion is assumed synchronized externally; no pulses during reset.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-029 Clean press: btn_raw[4] 0->1 held 30 cycles -> btn_level[4] rises at edge 6, btn_pulse[4] high only cycle 6, no further pulses (masked); release -> level falls 6 cycles later, no pulse.
REQ-030 Bounce: btn_raw[0] toggles 1,1,1,0 repeated for 20 cycles -> btn_level[0] and btn_pulse[0] stay 0.
REQ-031 Auto-repeat: btn_raw[3] held 25 cycles -> pulses at cycles 6, 16, 19, 22, 25 (while held); release -> FSM IDLE, no pulse.
REQ-032 Release race: btn_level[1] falls in the cycle a repeat is due -> no pulse that cycle, FSM IDLE.
REQ-033 Simultaneous: btn_raw[0] and btn_raw[2] rise same cycle -> btn_pulse = 5'b00101 in one cycle.
REQ-034 Async reset: rst_n pulsed low between edges during REPEAT with raw held -> outputs 0 before next edge; after release, single pulse at edge 6 then repeat timing restarts from DELAY.
